iccm_prog_loader: RTL and testbench
===================================

// Module: iccm_prog_loader
// PURPOSE
//  Upstream program loader for the instruction memory. Packs a byte stream (from the boot UART receiver) into
//  32-bit words and writes them sequentially into ICCM via the iccm_ctrl_* port. Holds the core's program
//  reset low while loading; releases it when an end-marker word arrives.
// PARAMETERS
//  AddrW      12              ICCM word-address width
//  EndMarker  32'h0000_0FFF   word that terminates loading; never written to ICCM
//  TimeoutCyc 16'd50000       idle cycles before a partial word is discarded (ICCM_LOADER_TIMEOUT_EN only)
// PORTS
//  clk_i          in   1      system clock
//  rst_ni         in   1      asynchronous active-low reset
//  rx_byte_i      in   8      received byte
//  rx_valid_i     in   1      rx_byte_i valid for one cycle; always accepted, no back-pressure
//  reload_i       in   1      pulse: re-enter loading from address 0 (honoured only in DONE)
//  iccm_addr_o    out  AddrW  ICCM write word address
//  iccm_wdata_o   out  32     ICCM write data
//  iccm_we_o      out  1      ICCM write strobe, one-cycle pulse per word
//  prog_rst_no    out  1      core program reset, active low; low while loading
//  overflow_o     out  1      sticky: a word arrived after ICCM was full
// BEHAVIOUR
//  - Reset values: iccm_addr_o=0, iccm_wdata_o=0, iccm_we_o=0, prog_rst_no=0, overflow_o=0, byte_cnt=0, state=LOAD.
//  - FSM states: LOAD (prog_rst_no=0), DONE (prog_rst_no=1).
//    LOAD->DONE when a completed word equals EndMarker. DONE->LOAD on reload_i.
//  - On DONE->LOAD: addr=0, byte_cnt=0, overflow_o cleared.
//  - Byte packing is little-endian. Byte 0 -> [7:0], byte 3 -> [31:24], via shift
//    word_q <= {rx_byte_i, word_q[31:8]}. A 2-bit byte_cnt wraps 3->0.
//  - Latency: the 4th byte is sampled at edge N. On edge N+1:
//    - if the word is not EndMarker and not full: iccm_we_o=1 for exactly that cycle, with
//      iccm_wdata_o=word and iccm_addr_o=current address. The address increments at the end of the pulse.
//    - if the word is EndMarker: no write; prog_rst_no goes high at edge N+1.
//  - Outputs are registered; no combinational path from rx_* to iccm_* or prog_rst_no.
//  - iccm_addr_o and iccm_wdata_o hold their values between pulses.
//  - A new byte may arrive in the same cycle as a we pulse. Packing continues without loss.
//  - Full: after writing address 2^AddrW-1, the loader is full and the address does not wrap.
//    Further non-marker words are dropped and set overflow_o. EndMarker is still recognised.
//  - In DONE, rx_valid_i is ignored. The byte counter stays at 0.
//  - reload_i in LOAD has no effect. reload_i at the same time as a marker completion: the marker wins
//    (go to DONE); the reload is lost.
//  - Async reset mid-word or mid-pulse: everything returns to reset values immediately; the partial word is discarded.
// CONFIGURATION
//  ICCM_LOADER_TIMEOUT_EN defined:
//    - In LOAD with byte_cnt!=0, a 16-bit idle counter counts cycles without rx_valid_i.
//    - At TimeoutCyc the counter resets byte_cnt to 0 and discards the partial word. No write, no state change.
//    - The counter clears on every rx_valid_i and whenever byte_cnt==0.
//  Not defined: no counter logic; a partial word waits indefinitely.
// STRUCTURE
//  - iccm_loader_pkg: loader_state_e {LOAD, DONE}; default END_MARKER constant; ICCM_AW=12.
//  - Sub-module iccm_word_packer: byte shift register, byte_cnt, and word_valid pulse (plus the timeout
//    counter when enabled).
//  - The top level holds the FSM, address counter, output registers and overflow flag.
// TESTING
//  1. Reset, then bytes 78,56,34,12 -> one we pulse, addr=0, wdata=32'h1234_5678; prog_rst_no stays 0.
//  2. Three words, then FF,0F,00,00 -> writes at addr 0,1,2; no 4th write; prog_rst_no=1 one cycle after the last byte.
//  3. Back-to-back bytes every cycle for 8 bytes -> two we pulses exactly 4 cycles apart, no byte lost.
//  4. Preload addr to 4095 via 4096 words, then one more word -> no we pulse, overflow_o=1;
//     then marker -> prog_rst_no=1.
//  5. In DONE, pulse reload_i, then send one word -> prog_rst_no=0, write at addr 0, overflow_o=0.
//  6. Assert rst_ni low after 2 bytes, then release and send 4 bytes -> the single word contains only
//     the new bytes. With ICCM_LOADER_TIMEOUT_EN, TimeoutCyc=10: 2 bytes, 10 idle cycles, 4 bytes ->
//     one write of the last 4 bytes.

Source files
------------

// File: rtl/iccm_loader_pkg.sv
// Shared types and defaults for the ICCM program loader.
// Optional idle timeout is enabled by defining ICCM_LOADER_TIMEOUT_EN.
package iccm_loader_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        DONE = 1'b1
    } loader_state_e;

    localparam int          ICCM_AW     = 12;
    localparam logic [31:0] END_MARKER  = 32'h0000_0FFF;
    localparam logic [15:0] TIMEOUT_CYC = 16'd50000;

endpackage

// File: rtl/iccm_prog_loader_if.sv
// Byte-stream input and ICCM write-port bundle for the program loader.
// The loader side uses the slave modport; the byte source / memory side uses master.
interface iccm_prog_loader_if #(
    parameter int AddrW = 12
);
    logic [7:0]       rx_byte_i;
    logic             rx_valid_i;
    logic             reload_i;
    logic [AddrW-1:0] iccm_addr_o;
    logic [31:0]      iccm_wdata_o;
    logic             iccm_we_o;
    logic             prog_rst_no;
    logic             overflow_o;

    modport slave (
        input  rx_byte_i, rx_valid_i, reload_i,
        output iccm_addr_o, iccm_wdata_o, iccm_we_o, prog_rst_no, overflow_o
    );

    modport master (
        output rx_byte_i, rx_valid_i, reload_i,
        input  iccm_addr_o, iccm_wdata_o, iccm_we_o, prog_rst_no, overflow_o
    );
endinterface

// File: rtl/iccm_word_packer.sv
// Packs a little-endian byte stream into 32-bit words with a one-cycle valid pulse.
// With ICCM_LOADER_TIMEOUT_EN, a partial word is dropped after TimeoutCyc idle cycles.
module iccm_word_packer
    import iccm_loader_pkg::*;
#(
    parameter logic [15:0] TimeoutCyc = TIMEOUT_CYC
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    input  logic        i_flush,
    output logic [31:0] o_word,
    output logic        o_wordValid
);

    logic [31:0] r_word;
    logic [1:0]  r_byteCnt;
    logic        r_wordValid;
    logic        w_timeout;

`ifdef ICCM_LOADER_TIMEOUT_EN
    logic [15:0] r_idleCnt;

    assign w_timeout = (r_byteCnt != 2'd0) && !i_valid && (r_idleCnt == TimeoutCyc - 16'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idleCnt <= 16'd0;
        end else if (i_flush || i_valid || (r_byteCnt == 2'd0) || w_timeout) begin
            r_idleCnt <= 16'd0;
        end else begin
            r_idleCnt <= r_idleCnt + 16'd1;
        end
    end
`else
    logic w_unusedTimeout;

    assign w_unusedTimeout = ^TimeoutCyc;
    assign w_timeout       = 1'b0;
`endif

    // Flush wins over an incoming byte so nothing leaks into DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word      <= 32'd0;
            r_byteCnt   <= 2'd0;
            r_wordValid <= 1'b0;
        end else begin
            r_wordValid <= 1'b0;
            if (i_flush) begin
                r_byteCnt <= 2'd0;
            end else if (i_valid) begin
                r_word    <= {i_byte, r_word[31:8]};
                r_byteCnt <= r_byteCnt + 2'd1;
                if (r_byteCnt == 2'd3) begin
                    r_wordValid <= 1'b1;
                end
            end else if (w_timeout) begin
                r_byteCnt <= 2'd0;
            end
        end
    end

    assign o_word      = r_word;
    assign o_wordValid = r_wordValid;

endmodule

// File: rtl/iccm_prog_loader.sv
// Boot program loader: writes packed words sequentially into ICCM and holds the core
// in reset until the end marker arrives. Optional timeout: ICCM_LOADER_TIMEOUT_EN.
module iccm_prog_loader
    import iccm_loader_pkg::*;
#(
    parameter int          AddrW      = ICCM_AW,
    parameter logic [31:0] EndMarker  = END_MARKER,
    parameter logic [15:0] TimeoutCyc = TIMEOUT_CYC
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    iccm_prog_loader_if.slave bus
);

    localparam logic [0:0] ST_LOAD = LOAD;
    localparam logic [0:0] ST_DONE = DONE;

    logic [0:0]       r_state;
    logic [AddrW-1:0] r_addr;
    logic             r_full;
    logic [AddrW-1:0] r_iccmAddr;
    logic [31:0]      r_iccmWdata;
    logic             r_iccmWe;
    logic             r_overflow;

    logic [31:0]      w_word;
    logic             w_wordValid;
    logic             w_markerHit;
    logic             w_flush;

    // Flushing on the marker cycle keeps a byte that races the state change out of DONE.
    assign w_markerHit = w_wordValid && (w_word == EndMarker);
    assign w_flush     = (r_state == ST_DONE) || w_markerHit;

    iccm_word_packer #(
        .TimeoutCyc (TimeoutCyc)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .i_byte      (bus.rx_byte_i),
        .i_valid     (bus.rx_valid_i),
        .i_flush     (w_flush),
        .o_word      (w_word),
        .o_wordValid (w_wordValid)
    );

    // r_addr is the next slot to write; it saturates at the top and r_full blocks further writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_LOAD;
            r_addr      <= '0;
            r_full      <= 1'b0;
            r_iccmAddr  <= '0;
            r_iccmWdata <= 32'd0;
            r_iccmWe    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_iccmWe <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_wordValid) begin
                        if (w_markerHit) begin
                            r_state <= ST_DONE;
                        end else if (!r_full) begin
                            r_iccmWe    <= 1'b1;
                            r_iccmWdata <= w_word;
                            r_iccmAddr  <= r_addr;
                            if (r_addr == {AddrW{1'b1}}) begin
                                r_full <= 1'b1;
                            end else begin
                                r_addr <= r_addr + AddrW'(1);
                            end
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.reload_i) begin
                        r_state    <= ST_LOAD;
                        r_addr     <= '0;
                        r_iccmAddr <= '0;
                        r_full     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.iccm_addr_o  = r_iccmAddr;
    assign bus.iccm_wdata_o = r_iccmWdata;
    assign bus.iccm_we_o    = r_iccmWe;
    assign bus.prog_rst_no  = (r_state == ST_DONE);
    assign bus.overflow_o   = r_overflow;

endmodule

// File: tb/tb_iccm_prog_loader.sv
// Self-checking bench for iccm_prog_loader: a queue-based model predicts every ICCM write
// and the done/overflow flags from the byte stream.
module tb_iccm_prog_loader;

    localparam int          AW     = 12;
    localparam int          DEPTH  = 1 << AW;
    localparam logic [31:0] MARKER = 32'h0000_0FFF;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        logic        expDone;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    // model state
    logic [7:0] modelBytes[$];
    wr_t        expWrites[$];
    int         modelAddr = 0;
    bit         modelDone = 0;
    bit         modelOverflow = 0;
    int         writeCount = 0;
    int         weCycles[$];

    iccm_prog_loader_if #(.AddrW(AW)) bus ();

    iccm_prog_loader dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every write pulse must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n && bus.iccm_we_o === 1'b1) begin
            writeCount++;
            weCycles.push_back(cycle);
            if (expWrites.size() == 0) begin
                checkOutput("unexpectedWrite", {20'd0, bus.iccm_addr_o}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = expWrites.pop_front();
                checkOutput("writeAddr", {20'd0, bus.iccm_addr_o}, w.addr);
                checkOutput("writeData", bus.iccm_wdata_o, w.data);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap = 0);
        logic [31:0] w;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.rx_byte_i  = b;
        bus.rx_valid_i = 1'b1;
        if (!modelDone) begin
            modelBytes.push_back(b);
            if (modelBytes.size() == 4) begin
                w = {modelBytes[3], modelBytes[2], modelBytes[1], modelBytes[0]};
                modelBytes.delete();
                if (w == MARKER) modelDone = 1;
                else if (modelAddr < DEPTH) begin
                    expWrites.push_back('{addr: modelAddr, data: w});
                    modelAddr++;
                end else modelOverflow = 1;
            end
        end
        @(posedge clk);
        #1 bus.rx_valid_i = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap = 0);
        for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], gap);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        modelBytes.delete();
        expWrites.delete();
        modelAddr = 0;
        modelDone = 0;
        modelOverflow = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulseReload();
        @(negedge clk);
        bus.reload_i = 1'b1;
        if (modelDone) begin
            modelDone = 0;
            modelAddr = 0;
            modelOverflow = 0;
            modelBytes.delete();
        end
        @(posedge clk);
        #1 bus.reload_i = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 20 && expWrites.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput(name, expWrites.size(), 0);
    endtask

    task automatic checkFlags(input string name);
        checkOutput({name, "_progRst"}, {31'd0, bus.prog_rst_no}, {31'd0, modelDone});
        checkOutput({name, "_overflow"}, {31'd0, bus.overflow_o}, {31'd0, modelOverflow});
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        if (w == MARKER) w = w ^ 32'h1;
        return w;
    endfunction

    initial begin
        vec_t vecs[6];
        int   n0;

        bus.rx_byte_i  = 8'd0;
        bus.rx_valid_i = 1'b0;
        bus.reload_i   = 1'b0;
        vecs[0] = '{word: 32'h1234_5678, expDone: 1'b0};
        vecs[1] = '{word: 32'hDEAD_BEEF, expDone: 1'b0};
        vecs[2] = '{word: 32'h0000_0FFE, expDone: 1'b0};
        vecs[3] = '{word: 32'h0FFF_0000, expDone: 1'b0};
        vecs[4] = '{word: 32'hFFFF_F0FF, expDone: 1'b0};
        vecs[5] = '{word: MARKER,        expDone: 1'b1};

        // reset values
        repeat (2) @(negedge clk);
        checkOutput("rstWe", {31'd0, bus.iccm_we_o}, 0);
        checkOutput("rstAddr", {20'd0, bus.iccm_addr_o}, 0);
        checkOutput("rstWdata", bus.iccm_wdata_o, 0);
        checkOutput("rstProg", {31'd0, bus.prog_rst_no}, 0);
        checkOutput("rstOvf", {31'd0, bus.overflow_o}, 0);
        rst_n = 1'b1;

        // single word
        sendWord(32'h1234_5678);
        waitDrain("t1Drain");
        checkOutput("t1Count", writeCount, 1);
        checkFlags("t1");

        // three words then marker; done exactly one edge after the last byte
        resetDut();
        n0 = writeCount;
        for (int i = 0; i < 3; i++) sendWord(randWord());
        sendWord(MARKER);
        checkOutput("t2ProgBefore", {31'd0, bus.prog_rst_no}, 0);
        @(posedge clk);
        #1 checkOutput("t2ProgAfter", {31'd0, bus.prog_rst_no}, 1);
        waitDrain("t2Drain");
        checkOutput("t2Count", writeCount - n0, 3);

        // back-to-back bytes
        resetDut();
        weCycles.delete();
        sendWord(32'hA1A2_A3A4);
        sendWord(32'hB1B2_B3B4);
        waitDrain("t3Drain");
        checkOutput("t3Pulses", weCycles.size(), 2);
        if (weCycles.size() == 2) checkOutput("t3Spacing", weCycles[1] - weCycles[0], 4);

        // table vectors
        resetDut();
        for (int i = 0; i < 6; i++) begin
            sendWord(vecs[i].word);
            repeat (2) @(negedge clk);
            checkOutput("tblDone", {31'd0, bus.prog_rst_no}, {31'd0, vecs[i].expDone});
        end
        waitDrain("tblDrain");

        // random words with random byte gaps
        resetDut();
        for (int i = 0; i < 40; i++) sendWord(randWord(), $urandom_range(0, 3));
        waitDrain("rndDrain");
        checkFlags("rnd");

        // fill, overflow, marker still recognised
        resetDut();
        for (int i = 0; i < DEPTH; i++) sendWord(randWord());
        waitDrain("fullDrain");
        checkFlags("full");
        n0 = writeCount;
        sendWord(32'h5555_AAAA);
        repeat (3) @(negedge clk);
        checkOutput("ovfNoWrite", writeCount - n0, 0);
        checkFlags("ovf");
        sendWord(MARKER);
        repeat (2) @(negedge clk);
        checkFlags("ovfMarker");

        // DONE ignores bytes, reload restarts at address 0
        sendWord(32'h0BAD_F00D);
        repeat (3) @(negedge clk);
        checkOutput("doneIgnore", writeCount - n0, 0);
        pulseReload();
        checkFlags("reload");
        sendWord(32'hCAFE_0001);
        waitDrain("reloadDrain");
        checkOutput("reloadCount", writeCount - n0, 1);

        // reset mid-word discards the partial bytes
        resetDut();
        applyStimulus(8'hEE);
        applyStimulus(8'hDD);
        resetDut();
        sendWord(32'h8765_4321);
        waitDrain("t6Drain");

        // reload in LOAD has no effect, even mid-word
        applyStimulus(8'h11);
        pulseReload();
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        waitDrain("reloadInLoad");
        checkFlags("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule
